// File: rtl/train_segment_tracker.sv
// train_segment_tracker: follows a train along a chain of track sensors, learns
// segment transit times and drives a timeout alarm and a crossing barrier.
//
// state | meaning
// IDLE  | track empty, waiting for an edge on sensor 0
// RUN   | train between sensors, timer counting down to the predicted arrival
// ALARM | expected sensor overdue; left only by that sensor or by reset
module train_segment_tracker #(
  parameter int N_SENSORS = 6,
  parameter int TW        = 19,
  parameter int PRESCALE  = 50000,
  parameter int T_DEFAULT = 1000,
  parameter int GATE_LEAD = 100,
  parameter bit WRAP      = 1'b0,
  localparam int SW       = (N_SENSORS > 2) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SENSORS-1:0] sensor,
  output logic [SW-1:0]        present_state,
  output logic [TW-1:0]        t_measured,
  output logic [TW-1:0]        t_predict,
  output logic                 alarm,
  output logic                 barrier,
  output logic                 seq_err
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_SENSORS - 1);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;
  state_t state, state_nxt;

  logic [N_SENSORS-1:0] sync1, sync2, sync3, edges, exp_mask;
  logic [1:0]           settle;
  logic [PW-1:0]        presc, presc_nxt;
  logic [TW-1:0]        timer, timer_nxt, elapsed, elapsed_nxt, pred, tmr_sat;
  logic [TW-1:0]        tm_nxt, tp_nxt;
  logic [TW:0]          sum, tmr_sum;
  logic [SW-1:0]        exp_idx, ps_nxt;
  logic                 hist_valid, hist_nxt, seq_err_nxt, alarm_nxt, barrier_nxt;
  logic                 exp_hit, other_hit, tick;

  // settle masks the first samples after reset so a line already high is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      settle <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      sync3 <= sync2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  always_comb begin
    edges     = (settle == 2'd3) ? (sync2 & ~sync3) : '0;
    exp_idx   = (present_state == LAST) ? '0 : present_state + 1'b1;
    exp_mask  = N_SENSORS'(1) << exp_idx;
    exp_hit   = |(edges & exp_mask);
    other_hit = |(edges & ~exp_mask);
    tick      = (state != IDLE) && (presc == PW'(PRESCALE - 1));
    sum       = {1'b0, elapsed} + {1'b0, t_measured};
    pred      = hist_valid ? TW'(sum >> 1) : elapsed;
    tmr_sum   = {1'b0, pred} + (TW+1)'(pred >> 1);
    tmr_sat   = tmr_sum[TW] ? '1 : tmr_sum[TW-1:0];
  end

  always_comb begin
    state_nxt   = state;
    ps_nxt      = present_state;
    tm_nxt      = t_measured;
    tp_nxt      = t_predict;
    timer_nxt   = timer;
    elapsed_nxt = elapsed;
    presc_nxt   = presc;
    hist_nxt    = hist_valid;
    seq_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (edges[0]) begin
          state_nxt   = RUN;
          ps_nxt      = '0;
          elapsed_nxt = '0;
          timer_nxt   = TW'(T_DEFAULT);
          hist_nxt    = 1'b0;
          presc_nxt   = '0;
        end
      end
      default: begin
        seq_err_nxt = other_hit;
        if (exp_hit) begin
          // an arrival beats a same-cycle timer expiry
          tm_nxt      = elapsed;
          tp_nxt      = pred;
          timer_nxt   = tmr_sat;
          elapsed_nxt = '0;
          presc_nxt   = '0;
          hist_nxt    = 1'b1;
          ps_nxt      = exp_idx;
          state_nxt   = (!WRAP && exp_idx == LAST) ? IDLE : RUN;
        end else begin
          presc_nxt = tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (elapsed != '1) elapsed_nxt = elapsed + 1'b1;
            if (timer != '0) timer_nxt = timer - 1'b1;
          end
          if (state == RUN && timer == '0) state_nxt = ALARM;
        end
      end
    endcase
    alarm_nxt   = (state_nxt == ALARM);
    barrier_nxt = (state == ALARM) || (state == RUN && int'(timer) <= GATE_LEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      present_state <= '0;
      t_measured    <= '0;
      t_predict     <= '0;
      alarm         <= 1'b0;
      barrier       <= 1'b0;
      seq_err       <= 1'b0;
      timer         <= '0;
      elapsed       <= '0;
      presc         <= '0;
      hist_valid    <= 1'b0;
    end else begin
      present_state <= ps_nxt;
      t_measured    <= tm_nxt;
      t_predict     <= tp_nxt;
      alarm         <= alarm_nxt;
      barrier       <= barrier_nxt;
      seq_err       <= seq_err_nxt;
      timer         <= timer_nxt;
      elapsed       <= elapsed_nxt;
      presc         <= presc_nxt;
      hist_valid    <= hist_nxt;
    end
  end
endmodule

// File: tb/tb_train_segment_tracker.sv
// Bench for train_segment_tracker: a linear TW=8 instance and a loop TW=4 instance
// checked against an arithmetic model of segment timing.
module tb_train_segment_tracker;
  localparam int PRE = 4;
  localparam int GL  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sen0 = '0;
  logic [3:0] sen1 = '0;
  logic [1:0] ps0, ps1;
  logic [7:0] tm0, tp0;
  logic [3:0] tm1, tp1;
  logic       al0, bar0, se0, al1, bar1, se1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // model: per instance, last accept cycle, measured/predicted times, timer loaded at accept
  int m_last[2], m_tm[2], m_tp[2], m_timer[2], m_ps[2];
  bit m_hist[2], m_active[2];
  int tmax[2] = '{255, 15};
  int tdef[2] = '{20, 10};
  bit wrapv[2] = '{1'b0, 1'b1};

  train_segment_tracker #(.N_SENSORS(4), .TW(8), .PRESCALE(PRE), .T_DEFAULT(20),
                          .GATE_LEAD(GL), .WRAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sensor(sen0), .present_state(ps0), .t_measured(tm0),
    .t_predict(tp0), .alarm(al0), .barrier(bar0), .seq_err(se0));

  train_segment_tracker #(.N_SENSORS(4), .TW(4), .PRESCALE(PRE), .T_DEFAULT(10),
                          .GATE_LEAD(GL), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .sensor(sen1), .present_state(ps1), .t_measured(tm1),
    .t_predict(tp1), .alarm(al1), .barrier(bar1), .seq_err(se1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // raise mask so its outputs land on posedge acc; sample afterwards at negedge cyc==acc
  task automatic drive(input int inst, input logic [3:0] mask, input int acc);
    wait_until(acc - 3);
    if (inst == 0) sen0 = mask; else sen1 = mask;
    wait_until(acc);
    if (inst == 0) sen0 = '0; else sen1 = '0;
  endtask

  task automatic accept(input int inst, input int idx, input logic [3:0] mask, input int acc);
    int d, e, p;
    d = acc - m_last[inst];
    drive(inst, mask, acc);
    if (!m_active[inst]) begin
      m_active[inst] = 1'b1; m_ps[inst] = 0; m_timer[inst] = tdef[inst]; m_hist[inst] = 1'b0;
    end else begin
      e = (d - 1) / PRE;
      if (e > tmax[inst]) e = tmax[inst];
      p = m_hist[inst] ? (e + m_tm[inst]) / 2 : e;
      m_tm[inst] = e; m_tp[inst] = p;
      m_timer[inst] = (p + p / 2 > tmax[inst]) ? tmax[inst] : p + p / 2;
      m_hist[inst] = 1'b1; m_ps[inst] = idx;
      if (!wrapv[inst] && idx == 3) m_active[inst] = 1'b0;
    end
    m_last[inst] = acc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sen0 = 4'b0001;
    repeat (3) @(negedge clk);
    checks++; if (ps0 !== 2'd0) begin failures++; $display("FAIL rst_ps: got %0d want 0", ps0); end
    checks++; if (tm0 !== 8'd0) begin failures++; $display("FAIL rst_tm: got %0d want 0", tm0); end
    checks++; if (tp0 !== 8'd0) begin failures++; $display("FAIL rst_tp: got %0d want 0", tp0); end
    checks++; if ({al0, bar0, se0} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b want 000", {al0, bar0, se0}); end
    checks++; if ({ps1, tm1, tp1, al1, bar1, se1} !== 13'd0) begin failures++; $display("FAIL rst_wrap_inst: got %h want 0", {ps1, tm1, tp1, al1, bar1, se1}); end
    rst_n = 1'b1;
  endtask

  task automatic test_hold_release;
    repeat (6) @(negedge clk);
    sen0 = '0;
    repeat (2) @(negedge clk);
    drive(0, 4'b0010, cyc + 4);
    checks++; if (ps0 !== 2'd0) begin failures++; $display("FAIL hold_ps: got %0d want 0", ps0); end
    checks++; if (se0 !== 1'b0) begin failures++; $display("FAIL hold_seq_err: got %0d want 0", se0); end
  endtask

  task automatic test_normal;
    int a, a2, kb;
    a = cyc + 5;
    accept(0, 0, 4'b0001, a);
    checks++; if (ps0 !== 2'd0 || al0 !== 1'b0) begin failures++; $display("FAIL norm_start: got ps=%0d al=%0d want 0 0", ps0, al0); end
    accept(0, 1, 4'b0010, a + 42);
    checks++; if (tm0 !== 8'd10 || tp0 !== 8'd10) begin failures++; $display("FAIL norm_s1: got tm=%0d tp=%0d want 10 10", tm0, tp0); end
    a2 = a + 92;
    accept(0, 2, 4'b0100, a2);
    checks++; if (tm0 !== 8'(m_tm[0]) || tp0 !== 8'(m_tp[0])) begin failures++; $display("FAIL norm_s2: got tm=%0d tp=%0d want %0d %0d", tm0, tp0, m_tm[0], m_tp[0]); end
    kb = (m_timer[0] - GL) * PRE + 1;
    wait_until(a2 + kb - 1);
    checks++; if (bar0 !== 1'b0) begin failures++; $display("FAIL norm_bar_early: got %0d want 0", bar0); end
    wait_until(a2 + kb);
    checks++; if (bar0 !== 1'b1 || al0 !== 1'b0) begin failures++; $display("FAIL norm_bar_close: got bar=%0d al=%0d want 1 0", bar0, al0); end
    accept(0, 3, 4'b1000, a2 + 60);
    checks++; if (ps0 !== 2'd3 || tm0 !== 8'(m_tm[0]) || tp0 !== 8'(m_tp[0])) begin failures++; $display("FAIL norm_s3: got ps=%0d tm=%0d tp=%0d want 3 %0d %0d", ps0, tm0, tp0, m_tm[0], m_tp[0]); end
    drive(0, 4'b0010, cyc + 5);
    checks++; if (ps0 !== 2'd3 || se0 !== 1'b0) begin failures++; $display("FAIL norm_idle_stray: got ps=%0d se=%0d want 3 0", ps0, se0); end
    wait_until(cyc + 2);
    checks++; if (bar0 !== 1'b0 || al0 !== 1'b0) begin failures++; $display("FAIL norm_idle_flags: got bar=%0d al=%0d want 0 0", bar0, al0); end
  endtask

  task automatic test_timeout;
    int a;
    a = cyc + 5;
    accept(0, 0, 4'b0001, a);
    wait_until(a + 20 * PRE);
    checks++; if (al0 !== 1'b0) begin failures++; $display("FAIL tmo_early: got %0d want 0", al0); end
    wait_until(a + 20 * PRE + 1);
    checks++; if (al0 !== 1'b1 || bar0 !== 1'b1) begin failures++; $display("FAIL tmo_alarm: got al=%0d bar=%0d want 1 1", al0, bar0); end
    accept(0, 1, 4'b0010, a + 102);
    checks++; if (tm0 !== 8'd25 || al0 !== 1'b0 || ps0 !== 2'd1) begin failures++; $display("FAIL tmo_recover: got tm=%0d al=%0d ps=%0d want 25 0 1", tm0, al0, ps0); end
    wait_until(a + 103);
    checks++; if (bar0 !== 1'b0) begin failures++; $display("FAIL tmo_run_bar: got %0d want 0", bar0); end
    accept(0, 2, 4'b0100, cyc + 8);
    accept(0, 3, 4'b1000, cyc + 8);
  endtask

  task automatic test_out_of_order;
    int a;
    a = cyc + 5;
    accept(0, 0, 4'b0001, a);
    drive(0, 4'b1000, a + 20);
    checks++; if (se0 !== 1'b1 || ps0 !== 2'd0) begin failures++; $display("FAIL ooo_pulse: got se=%0d ps=%0d want 1 0", se0, ps0); end
    @(negedge clk);
    checks++; if (se0 !== 1'b0 || ps0 !== 2'd0) begin failures++; $display("FAIL ooo_pulse_end: got se=%0d ps=%0d want 0 0", se0, ps0); end
    accept(0, 1, 4'b1010, a + 40);
    checks++; if (ps0 !== 2'd1 || se0 !== 1'b1 || tm0 !== 8'(m_tm[0])) begin failures++; $display("FAIL ooo_both: got ps=%0d se=%0d tm=%0d want 1 1 %0d", ps0, se0, tm0, m_tm[0]); end
    accept(0, 2, 4'b0100, cyc + 8);
    accept(0, 3, 4'b1000, cyc + 8);
  endtask

  task automatic test_random;
    int acc, k;
    bit exp_al, exp_bar;
    for (int trip = 0; trip < 3; trip++) begin
      for (int s = 0; s < 4; s++) begin
        acc = cyc + int'($urandom_range(110, 6));
        if (m_active[0]) begin
          wait_until(acc - 3);
          k = acc - 3 - m_last[0];
          exp_al = (k >= m_timer[0] * PRE + 1);
          exp_bar = ((m_timer[0] - (k - 1) / PRE) <= GL);
          checks++; if (al0 !== exp_al || bar0 !== exp_bar) begin failures++; $display("FAIL rnd_pre s%0d: got al=%0d bar=%0d want %0d %0d", s, al0, bar0, exp_al, exp_bar); end
        end
        accept(0, s, 4'(1 << s), acc);
        checks++; if (ps0 !== 2'(m_ps[0]) || tm0 !== 8'(m_tm[0]) || tp0 !== 8'(m_tp[0]) || al0 !== 1'b0) begin failures++; $display("FAIL rnd_acc s%0d: got ps=%0d tm=%0d tp=%0d al=%0d want %0d %0d %0d 0", s, ps0, tm0, tp0, al0, m_ps[0], m_tm[0], m_tp[0]); end
      end
    end
  endtask

  task automatic test_wrap;
    int acc, k;
    accept(1, 0, 4'b0001, cyc + 5);
    for (int s = 1; s < 5; s++) begin
      accept(1, s % 4, 4'(1 << (s % 4)), cyc + int'($urandom_range(20, 6)));
      checks++; if (ps1 !== 2'(m_ps[1]) || tm1 !== 4'(m_tm[1]) || tp1 !== 4'(m_tp[1]) || al1 !== 1'b0) begin failures++; $display("FAIL wrap_s%0d: got ps=%0d tm=%0d tp=%0d al=%0d want %0d %0d %0d 0", s, ps1, tm1, tp1, al1, m_ps[1], m_tm[1], m_tp[1]); end
    end
    acc = cyc + 30 * PRE + 3;
    wait_until(acc - 3);
    k = acc - 3 - m_last[1];
    checks++; if (al1 !== (k >= m_timer[1] * PRE + 1)) begin failures++; $display("FAIL sat_alarm: got %0d want %0d", al1, (k >= m_timer[1] * PRE + 1)); end
    accept(1, 1, 4'b0010, acc);
    checks++; if (tm1 !== 4'd15 || ps1 !== 2'd1 || tp1 !== 4'(m_tp[1])) begin failures++; $display("FAIL sat_tm: got tm=%0d ps=%0d tp=%0d want 15 1 %0d", tm1, ps1, tp1, m_tp[1]); end
  endtask

  task automatic test_async_reset;
    int a;
    bit exp_al;
    a = cyc + 5;
    accept(0, 0, 4'b0001, a);
    accept(0, 1, 4'b0010, a + 10);
    wait_until(a + 26);
    exp_al = (16 >= m_timer[0] * PRE + 1);
    checks++; if (al0 !== exp_al || ps0 !== 2'd1 || tm0 !== 8'(m_tm[0])) begin failures++; $display("FAIL ares_pre: got al=%0d ps=%0d tm=%0d want %0d 1 %0d", al0, ps0, tm0, exp_al, m_tm[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ps0, tm0, tp0, al0, bar0, se0} !== 21'd0) begin failures++; $display("FAIL ares_main: got %h want 0", {ps0, tm0, tp0, al0, bar0, se0}); end
    checks++; if ({ps1, tm1, tp1, al1, bar1, se1} !== 13'd0) begin failures++; $display("FAIL ares_wrap: got %h want 0", {ps1, tm1, tp1, al1, bar1, se1}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hold_release();
    test_normal();
    test_timeout();
    test_out_of_order();
    test_random();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
